// File: rtl/tx_len_mux_stream.sv
// Length-specified multi-channel transmitter: takes a 5-byte command and streams
// that many bytes from the selected channel FIFO as DATA_BYTES-wide AXI-stream beats.
module tx_len_mux_stream #(
   parameter int NCH        = 4,
   parameter int DATA_BYTES = 4,
   parameter int CNT_W      = 8,
   parameter int THRESH     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic                          i_tready,
   input  logic                          i_tvalid,
   input  logic [7:0]                    i_tdata,
   input  logic                          o_tready,
   output logic                          o_tvalid,
   output logic [8*DATA_BYTES-1:0]       o_tdata,
   output logic [DATA_BYTES-1:0]         o_tkeep,
   output logic                          o_tlast,
   output logic [NCH-1:0]                ch_rden,
   input  logic [NCH*8*DATA_BYTES-1:0]   ch_rdata,
   input  logic [NCH*CNT_W-1:0]          ch_count,
   output logic                          busy,
   output logic                          done,
   output logic                          cmd_err
);

   localparam int W  = 8 * DATA_BYTES;
   localparam int KW = $clog2(DATA_BYTES);

   typedef enum logic [2:0] {C0, C1, C2, C3, C4, HDR, DATA} state_t;

   state_t                state, state_n;
   logic [6:0]            ch;
   logic                  hdr;
   logic [31:0]           len;
   logic [31:0]           unread;
   logic [31:0]           beats_left;
   logic [DATA_BYTES-1:0] keep_last;
   logic [W-1:0]          buf_mem [2];
   logic                  head, wr_ptr;
   logic [1:0]            occ;
   logic                  pending;
   logic                  done_n, err_n;

   logic [W-1:0]          rdata_sel;
   logic [CNT_W-1:0]      count_sel;
   logic [31:0]           count_ext;
   logic [31:0]           len_full;
   logic [32:0]           len_sum;
   logic [31:0]           words_full;
   logic [DATA_BYTES-1:0] keep_calc;
   logic                  cmd_fire, pop, rden, last_beat;
   logic [2:0]            fill;

   // Only the latched channel ever reaches the datapath.
   always_comb begin
      rdata_sel = '0;
      count_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch == 7'(i)) begin
            rdata_sel = ch_rdata[i*W +: W];
            count_sel = ch_count[i*CNT_W +: CNT_W];
         end
      end
   end

   assign count_ext  = 32'(count_sel);
   assign cmd_fire   = i_tvalid && i_tready;
   assign len_full   = {i_tdata, len[23:0]};
   assign len_sum    = {1'b0, len_full} + 33'(DATA_BYTES - 1);
   assign words_full = 32'(len_sum >> KW);

   always_comb begin
      keep_calc = '0;
      for (int b = 0; b < DATA_BYTES; b++)
         keep_calc[b] = (len_full[KW-1:0] == '0) || (KW'(b) < len_full[KW-1:0]);
   end

   // Space check counts the word in flight and the word leaving this cycle.
   assign pop  = (state == DATA) && (occ != 2'd0) && o_tready;
   assign fill = {1'b0, occ} + {2'b0, pending} - {2'b0, pop};
   assign rden = (state == DATA) && (unread != 32'd0) && (fill < 3'd2) &&
                 (count_ext > {31'b0, pending}) &&
                 ((count_ext >= 32'(THRESH)) || (count_ext >= unread));

   always_comb begin
      ch_rden = '0;
      for (int i = 0; i < NCH; i++)
         ch_rden[i] = rden && (ch == 7'(i));
   end

   assign i_tready  = (state == C0) || (state == C1) || (state == C2) ||
                      (state == C3) || (state == C4);
   assign busy      = (state != C0);
   assign last_beat = (beats_left == 32'd1);

   always_comb begin
      o_tvalid = 1'b0;
      o_tdata  = '0;
      o_tkeep  = '0;
      o_tlast  = 1'b0;
      if (state == HDR) begin
         o_tvalid       = 1'b1;
         o_tdata[31:0]  = {1'b0, ch, len[23:0]};
         o_tkeep        = '1;
         o_tlast        = (len == 32'd0);
      end else if (state == DATA) begin
         o_tvalid = (occ != 2'd0);
         o_tdata  = buf_mem[head];
         o_tkeep  = last_beat ? keep_last : '1;
         o_tlast  = last_beat;
      end
   end

   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         C0: if (cmd_fire) state_n = C1;
         C1: if (cmd_fire) state_n = C2;
         C2: if (cmd_fire) state_n = C3;
         C3: if (cmd_fire) state_n = C4;
         C4: begin
            if (cmd_fire) begin
               if (32'(ch) >= NCH) begin
                  err_n   = 1'b1;
                  state_n = C0;
               end else if (len_full == 32'd0 && !hdr) begin
                  done_n  = 1'b1;
                  state_n = C0;
               end else if (hdr) begin
                  state_n = HDR;
               end else begin
                  state_n = DATA;
               end
            end
         end
         HDR: begin
            if (o_tready) begin
               if (len == 32'd0) begin
                  done_n  = 1'b1;
                  state_n = C0;
               end else begin
                  state_n = DATA;
               end
            end
         end
         DATA: begin
            if (pop && last_beat) begin
               done_n  = 1'b1;
               state_n = C0;
            end
         end
         default: state_n = C0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= C0;
         ch         <= '0;
         hdr        <= 1'b0;
         len        <= '0;
         unread     <= '0;
         beats_left <= '0;
         keep_last  <= '0;
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         head       <= 1'b0;
         wr_ptr     <= 1'b0;
         occ        <= '0;
         pending    <= 1'b0;
         done       <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         state   <= state_n;
         done    <= done_n;
         cmd_err <= err_n;
         pending <= rden;
         occ     <= fill[1:0];
         if (cmd_fire) begin
            case (state)
               C0: begin
                  ch  <= i_tdata[6:0];
                  hdr <= i_tdata[7];
               end
               C1: len[7:0]   <= i_tdata;
               C2: len[15:8]  <= i_tdata;
               C3: len[23:16] <= i_tdata;
               C4: begin
                  len[31:24] <= i_tdata;
                  unread     <= words_full;
                  beats_left <= words_full;
                  keep_last  <= keep_calc;
               end
               default: ;
            endcase
         end
         if (rden) unread <= unread - 32'd1;
         // FIFO q is valid one cycle after the read request.
         if (pending) begin
            buf_mem[wr_ptr] <= rdata_sel;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            head       <= ~head;
            beats_left <= beats_left - 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_tx_len_mux_stream.sv
// Directed bench for tx_len_mux_stream: behavioural channel FIFOs, a beat monitor,
// and a linear sequence of commands checked with immediate assertions.
module tb_tx_len_mux_stream;

   localparam int NCH    = 4;
   localparam int DB     = 4;
   localparam int CNT_W  = 8;
   localparam int THRESH = 4;
   localparam int W      = 8 * DB;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 i_tready, i_tvalid;
   logic [7:0]           i_tdata;
   logic                 o_tready, o_tvalid, o_tlast;
   logic [W-1:0]         o_tdata;
   logic [DB-1:0]        o_tkeep;
   logic [NCH-1:0]       ch_rden;
   logic [NCH*W-1:0]     ch_rdata;
   logic [NCH*CNT_W-1:0] ch_count;
   logic                 busy, done, cmd_err;

   logic fixed_ready, use_rand, rnd_ready;

   always #5 clk = ~clk;

   tx_len_mux_stream #(.NCH(NCH), .DATA_BYTES(DB), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
      .clk(clk), .rst(rst),
      .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
      .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata),
      .o_tkeep(o_tkeep), .o_tlast(o_tlast),
      .ch_rden(ch_rden), .ch_rdata(ch_rdata), .ch_count(ch_count),
      .busy(busy), .done(done), .cmd_err(cmd_err)
   );

   assign o_tready = use_rand ? rnd_ready : fixed_ready;

   // Channel FIFOs: one-cycle read latency, rdusedw drops at the read edge.
   logic [W-1:0] mem [NCH][64];
   int           wr_idx [NCH];
   int           rd_idx [NCH];
   logic [W-1:0] fifo_q [NCH];

   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (ch_rden[c]) begin
            fifo_q[c] <= mem[c][rd_idx[c]];
            rd_idx[c] <= rd_idx[c] + 1;
         end
      end
   end

   always_comb begin
      ch_rdata = '0;
      ch_count = '0;
      for (int c = 0; c < NCH; c++) begin
         ch_rdata[c*W +: W]         = fifo_q[c];
         ch_count[c*CNT_W +: CNT_W] = CNT_W'(wr_idx[c] - rd_idx[c]);
      end
   end

   initial begin
      rnd_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rnd_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: inputs change just after posedge, so the negedge view is what the next edge sees.
   logic [W-1:0]  log_data [256];
   logic [DB-1:0] log_keep [256];
   logic          log_last [256];
   int            beat_cnt, done_cnt, err_cnt, rden_tot, onehot_err, hold_err;
   int            rden_ch [NCH];
   logic          stall_q;
   logic [W-1:0]  p_data;
   logic [DB-1:0] p_keep;
   logic          p_last;

   always @(negedge clk) begin
      if (o_tvalid && o_tready) begin
         log_data[beat_cnt] <= o_tdata;
         log_keep[beat_cnt] <= o_tkeep;
         log_last[beat_cnt] <= o_tlast;
         beat_cnt           <= beat_cnt + 1;
      end
      if (done)    done_cnt <= done_cnt + 1;
      if (cmd_err) err_cnt  <= err_cnt + 1;
      if (ch_rden != '0) rden_tot <= rden_tot + 1;
      if ($countones(ch_rden) > 1) onehot_err <= onehot_err + 1;
      for (int c = 0; c < NCH; c++)
         if (ch_rden[c]) rden_ch[c] <= rden_ch[c] + 1;
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         if (stall_q && (!o_tvalid || o_tdata !== p_data || o_tkeep !== p_keep || o_tlast !== p_last))
            hold_err <= hold_err + 1;
         stall_q <= o_tvalid && !o_tready;
         p_data  <= o_tdata;
         p_keep  <= o_tkeep;
         p_last  <= o_tlast;
      end
   end

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int cnt_of(input int sel);
      case (sel)
         0:       return done_cnt;
         1:       return err_cnt;
         default: return beat_cnt;
      endcase
   endfunction

   task automatic waitUntil(input int sel, input int target);
      int k;
      k = 0;
      while (cnt_of(sel) < target && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic push(input int c, input logic [W-1:0] w);
      mem[c][wr_idx[c]] = w;
      wr_idx[c]++;
   endtask

   task automatic sendByte(input logic [7:0] b);
      logic ok;
      ok       = 1'b0;
      i_tvalid = 1'b1;
      i_tdata  = b;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (i_tready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      i_tvalid = 1'b0;
      i_tdata  = '0;
      if (!ok) checkOutput("cmd_accept", 64'(ok), 64'd1);
   endtask

   task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4);
      sendByte(b0);
      sendByte(b1);
      sendByte(b2);
      sendByte(b3);
      sendByte(b4);
   endtask

   int b_beat, b_done, b_err, b_rden, b_rch, b_hold;

   task automatic snap(input int c);
      b_beat = beat_cnt;
      b_done = done_cnt;
      b_err  = err_cnt;
      b_rden = rden_tot;
      b_rch  = rden_ch[c];
      b_hold = hold_err;
   endtask

   initial begin
      rst         = 1'b1;
      i_tvalid    = 1'b0;
      i_tdata     = '0;
      fixed_ready = 1'b1;
      use_rand    = 1'b0;
      #2;
      checkOutput("rst_tvalid", 64'(o_tvalid), 64'd0);
      checkOutput("rst_rden",   64'(ch_rden),  64'd0);
      checkOutput("rst_busy",   64'(busy),     64'd0);
      checkOutput("rst_done",   64'(done),     64'd0);
      checkOutput("rst_err",    64'(cmd_err),  64'd0);
      checkOutput("rst_tready", 64'(i_tready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Two full words from channel 1, FIFO count below THRESH but covering the transfer.
      push(1, 32'h1111_1111);
      push(1, 32'h2222_2222);
      snap(1);
      applyStimulus(8'h01, 8'h08, 8'h00, 8'h00, 8'h00);
      waitUntil(0, b_done + 1);
      checkOutput("t1_busy_at_done", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t1_beats",  64'(beat_cnt - b_beat),  64'd2);
      checkOutput("t1_data0",  64'(log_data[b_beat]),   64'h1111_1111);
      checkOutput("t1_keep0",  64'(log_keep[b_beat]),   64'hF);
      checkOutput("t1_last0",  64'(log_last[b_beat]),   64'd0);
      checkOutput("t1_data1",  64'(log_data[b_beat+1]), 64'h2222_2222);
      checkOutput("t1_keep1",  64'(log_keep[b_beat+1]), 64'hF);
      checkOutput("t1_last1",  64'(log_last[b_beat+1]), 64'd1);
      checkOutput("t1_done",   64'(done_cnt - b_done),  64'd1);
      checkOutput("t1_rden",   64'(rden_tot - b_rden),  64'd2);
      checkOutput("t1_rden1",  64'(rden_ch[1] - b_rch), 64'd2);

      // Header then a 6-byte payload from channel 2.
      push(2, 32'hAAAA_0001);
      push(2, 32'hBBBB_0002);
      snap(2);
      applyStimulus(8'h82, 8'h06, 8'h00, 8'h00, 8'h00);
      waitUntil(0, b_done + 1);
      checkOutput("t2_beats", 64'(beat_cnt - b_beat),  64'd3);
      checkOutput("t2_hdr",   64'(log_data[b_beat]),   64'h0200_0006);
      checkOutput("t2_hkeep", 64'(log_keep[b_beat]),   64'hF);
      checkOutput("t2_hlast", 64'(log_last[b_beat]),   64'd0);
      checkOutput("t2_data1", 64'(log_data[b_beat+1]), 64'hAAAA_0001);
      checkOutput("t2_last1", 64'(log_last[b_beat+1]), 64'd0);
      checkOutput("t2_data2", 64'(log_data[b_beat+2]), 64'hBBBB_0002);
      checkOutput("t2_keep2", 64'(log_keep[b_beat+2]), 64'h3);
      checkOutput("t2_last2", 64'(log_last[b_beat+2]), 64'd1);
      checkOutput("t2_rden2", 64'(rden_ch[2] - b_rch), 64'd2);

      // Header-only command with zero length.
      snap(0);
      applyStimulus(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
      waitUntil(0, b_done + 1);
      checkOutput("t3_beats", 64'(beat_cnt - b_beat), 64'd1);
      checkOutput("t3_hdr",   64'(log_data[b_beat]),  64'h0);
      checkOutput("t3_keep",  64'(log_keep[b_beat]),  64'hF);
      checkOutput("t3_last",  64'(log_last[b_beat]),  64'd1);
      checkOutput("t3_done",  64'(done_cnt - b_done), 64'd1);
      checkOutput("t3_rden",  64'(rden_tot - b_rden), 64'd0);

      // Out-of-range channel, then a zero-length no-header command.
      snap(0);
      applyStimulus(8'h05, 8'h04, 8'h00, 8'h00, 8'h00);
      waitUntil(1, b_err + 1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("t4_err",   64'(err_cnt - b_err),   64'd1);
      checkOutput("t4_done",  64'(done_cnt - b_done), 64'd0);
      checkOutput("t4_rden",  64'(rden_tot - b_rden), 64'd0);
      checkOutput("t4_beats", 64'(beat_cnt - b_beat), 64'd0);
      checkOutput("t4_busy",  64'(busy),              64'd0);
      snap(0);
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      waitUntil(0, b_done + 1);
      checkOutput("t4z_done",  64'(done_cnt - b_done), 64'd1);
      checkOutput("t4z_beats", 64'(beat_cnt - b_beat), 64'd0);
      checkOutput("t4z_err",   64'(err_cnt - b_err),   64'd0);

      // 40 bytes from channel 3 with the FIFO filling slowly and random backpressure.
      for (int i = 0; i < 3; i++) push(3, 32'h3000_0000 + 32'(i));
      use_rand = 1'b1;
      snap(3);
      applyStimulus(8'h03, 8'h28, 8'h00, 8'h00, 8'h00);
      for (int i = 3; i < 10; i++) begin
         repeat (3) @(posedge clk);
         #1;
         push(3, 32'h3000_0000 + 32'(i));
      end
      waitUntil(0, b_done + 1);
      use_rand = 1'b0;
      checkOutput("t5_beats", 64'(beat_cnt - b_beat),  64'd10);
      checkOutput("t5_rden3", 64'(rden_ch[3] - b_rch), 64'd10);
      checkOutput("t5_hold",  64'(hold_err - b_hold),  64'd0);
      for (int i = 0; i < 10; i++)
         checkOutput($sformatf("t5_data%0d", i), 64'(log_data[b_beat+i]), 64'(32'h3000_0000 + 32'(i)));
      checkOutput("t5_keep9", 64'(log_keep[b_beat+9]), 64'hF);
      checkOutput("t5_last8", 64'(log_last[b_beat+8]), 64'd0);
      checkOutput("t5_last9", 64'(log_last[b_beat+9]), 64'd1);

      // Reset in the middle of a streaming transfer, then a fresh single-byte command.
      for (int i = 0; i < 8; i++) push(0, 32'h0C00_0000 + 32'(i));
      snap(0);
      applyStimulus(8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
      waitUntil(2, b_beat + 2);
      #2;
      checkOutput("t6_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      checkOutput("t6_tvalid", 64'(o_tvalid), 64'd0);
      checkOutput("t6_rden",   64'(ch_rden),  64'd0);
      checkOutput("t6_busy",   64'(busy),     64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      push(1, 32'h5A5A_5A5A);
      snap(1);
      applyStimulus(8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
      waitUntil(0, b_done + 1);
      checkOutput("t6_beats", 64'(beat_cnt - b_beat),  64'd1);
      checkOutput("t6_data",  64'(log_data[b_beat]),   64'h5A5A_5A5A);
      checkOutput("t6_keep",  64'(log_keep[b_beat]),   64'h1);
      checkOutput("t6_last",  64'(log_last[b_beat]),   64'd1);
      checkOutput("t6_rden1", 64'(rden_ch[1] - b_rch), 64'd1);

      checkOutput("onehot", 64'(onehot_err), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
